// File: rtl/dwt53_lift_stage.sv
// LeGall 5/3 forward lifting stage: pops (even, odd) FIFO pairs, emits (approx, detail) with edge extension.
// Optional DWT_SAT_EN: saturate outputs to DATA_W signed range instead of two's-complement wrap.
module dwt53_lift_stage #(
  parameter int DATA_W     = 16,
  parameter int LINE_PAIRS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] even_data,
  input  logic              even_empty,
  output logic              even_rd_en,
  input  logic [DATA_W-1:0] odd_data,
  input  logic              odd_empty,
  output logic              odd_rd_en,
  output logic [DATA_W-1:0] approx_out,
  output logic [DATA_W-1:0] detail_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int IW = DATA_W + 3;
  localparam int KW = $clog2(LINE_PAIRS + 1);
  localparam logic [KW-1:0] C_K_LAST = KW'(LINE_PAIRS - 1);
  localparam logic [KW-1:0] C_K_ONE  = KW'(1);
  localparam logic signed [IW-1:0] C_TWO  = IW'(2);
  localparam logic signed [IW-1:0] C_SMAX = {{4{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [IW-1:0] C_SMIN = {{4{1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_FLUSH, S_DONE} state_t;

  state_t r_state, w_next;

  logic [KW-1:0]           r_k;
  logic signed [IW-1:0]    r_e_prev, r_o_prev, r_d_prev;
  logic [DATA_W-1:0]       r_approx, r_detail;
  logic                    r_out_valid;

  logic                    w_out_free, w_fetch_go, w_flush_go, w_load, w_first;
  logic                    w_rd_en, w_busy, w_done;
  logic signed [IW-1:0]    w_e_cur, w_o_cur, w_e_next;
  logic signed [IW-1:0]    w_esum, w_d_new, w_d_left, w_dsum, w_s_new;

  function automatic logic [DATA_W-1:0] fit(input logic signed [IW-1:0] v);
`ifdef DWT_SAT_EN
    if (v > C_SMAX)      return C_SMAX[DATA_W-1:0];
    else if (v < C_SMIN) return C_SMIN[DATA_W-1:0];
    else                 return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  assign w_out_free = !r_out_valid || out_ready;
  assign w_fetch_go = (r_state == S_FETCH) && !even_empty && !odd_empty && w_out_free;
  assign w_flush_go = (r_state == S_FLUSH) && w_out_free;
  assign w_load     = ((r_state == S_LATCH) && (r_k != '0)) || w_flush_go;

  // The same datapath serves LATCH (right neighbour = new even) and FLUSH (right neighbour mirrored);
  // r_k==1 marks the first pair of the line in both states, which selects the left-edge mirror.
  assign w_e_cur  = {{3{even_data[DATA_W-1]}}, even_data};
  assign w_o_cur  = {{3{odd_data[DATA_W-1]}}, odd_data};
  assign w_e_next = (r_state == S_LATCH) ? w_e_cur : r_e_prev;
  assign w_first  = (r_k == C_K_ONE);
  assign w_esum   = r_e_prev + w_e_next;
  assign w_d_new  = r_o_prev - (w_esum >>> 1);
  assign w_d_left = w_first ? w_d_new : r_d_prev;
  assign w_dsum   = w_d_left + w_d_new + C_TWO;
  assign w_s_new  = r_e_prev + (w_dsum >>> 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (w_fetch_go) w_next = S_LATCH;
      S_LATCH: w_next = (r_k == C_K_LAST) ? S_FLUSH : S_FETCH;
      S_FLUSH: if (w_flush_go) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en = w_fetch_go;
    w_busy  = (r_state != S_IDLE);
    w_done  = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k         <= '0;
      r_e_prev    <= '0;
      r_o_prev    <= '0;
      r_d_prev    <= '0;
      r_approx    <= '0;
      r_detail    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) r_k <= '0;
      if (r_state == S_LATCH) begin
        r_e_prev <= w_e_cur;
        r_o_prev <= w_o_cur;
        if (r_k != '0) r_d_prev <= w_d_new;
        r_k <= r_k + KW'(1);
      end
      if (w_load) begin
        r_approx    <= fit(w_s_new);
        r_detail    <= fit(w_d_new);
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign even_rd_en = w_rd_en;
  assign odd_rd_en  = w_rd_en;
  assign busy       = w_busy;
  assign done       = w_done;
  assign approx_out = r_approx;
  assign detail_out = r_detail;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_dwt53_lift_stage.sv
// Bench for dwt53_lift_stage: FIFO model, directed spec cases, random lines against an arithmetic 5/3 model.
module tb_dwt53_lift_stage;
  localparam int DW = 16;
  localparam int NP = 4;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, out_ready = 1'b1, odd_hold = 1'b0, fifo_clr = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] even_data = '0, odd_data = '0, approx_out, detail_out;
  logic even_empty, odd_empty, even_rd_en, odd_rd_en, out_valid, busy, done;

  int fe[256], fo[256];
  int e_wr = 0, e_rd = 0, o_wr = 0, o_rd = 0;
  assign even_empty = (e_wr == e_rd);
  assign odd_empty  = (o_wr == o_rd) || odd_hold;

  dwt53_lift_stage #(.DATA_W(DW), .LINE_PAIRS(NP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .even_data(even_data), .even_empty(even_empty), .even_rd_en(even_rd_en),
    .odd_data(odd_data), .odd_empty(odd_empty), .odd_rd_en(odd_rd_en),
    .approx_out(approx_out), .detail_out(detail_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  // FIFO model: data appears the cycle after rd_en
  always @(posedge clk) begin
    if (fifo_clr) begin
      e_rd <= e_wr;
      o_rd <= o_wr;
    end else begin
      if (even_rd_en && e_rd != e_wr) begin even_data <= DW'(fe[e_rd % 256]); e_rd <= e_rd + 1; end
      if (odd_rd_en && o_rd != o_wr)  begin odd_data  <= DW'(fo[o_rd % 256]); o_rd <= o_rd + 1; end
    end
  end

  logic signed [DW-1:0] got_s[$], got_d[$];
  int viol = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin got_s.push_back(approx_out); got_d.push_back(detail_out); end
      if (even_rd_en !== odd_rd_en) viol++;
      if (even_rd_en && (even_empty || odd_empty || (out_valid && !out_ready))) viol++;
      if (done) done_cnt++;
    end
  end

  // Small-line instances fed by constant (never empty) FIFOs
  logic start1 = 1'b0, start2 = 1'b0, one = 1'b1, zero = 1'b0;
  logic [DW-1:0] e1 = 16'h0000, o1 = 16'hFFFD, e2 = 16'h8000, o2 = 16'h7FFF;
  logic [DW-1:0] a1, d1, a2, d2;
  logic re1, ro1, v1, b1, dn1, re2, ro2, v2, b2, dn2;

  dwt53_lift_stage #(.DATA_W(DW), .LINE_PAIRS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .even_data(e1), .even_empty(zero), .even_rd_en(re1),
    .odd_data(o1), .odd_empty(zero), .odd_rd_en(ro1),
    .approx_out(a1), .detail_out(d1), .out_valid(v1),
    .out_ready(one), .busy(b1), .done(dn1)
  );
  dwt53_lift_stage #(.DATA_W(DW), .LINE_PAIRS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .even_data(e2), .even_empty(zero), .even_rd_en(re2),
    .odd_data(o2), .odd_empty(zero), .odd_rd_en(ro2),
    .approx_out(a2), .detail_out(d2), .out_valid(v2),
    .out_ready(one), .busy(b2), .done(dn2)
  );
  logic signed [DW-1:0] g1s[$], g1d[$], g2s[$], g2d[$];
  always @(posedge clk) begin
    if (reset_n && v1) begin g1s.push_back(a1); g1d.push_back(d1); end
    if (reset_n && v2) begin g2s.push_back(a2); g2d.push_back(d2); end
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int fit(input int v);
`ifdef DWT_SAT_EN
    if (v > (1 << (DW - 1)) - 1) return (1 << (DW - 1)) - 1;
    if (v < -(1 << (DW - 1)))    return -(1 << (DW - 1));
    return v;
`else
    logic [DW-1:0] t;
    t = v[DW-1:0];
    return int'($signed(t));
`endif
  endfunction

  // d[i] = o[i] - floor((e[i]+e[i+1])/2), s[i] = e[i] + floor((d[i-1]+d[i]+2)/4), mirrored at both edges
  function automatic void model(input int n, input int e[4], input int o[4], output int s[4], output int d[4]);
    int dd[4];
    for (int i = 0; i < 4; i++) begin s[i] = 0; d[i] = 0; dd[i] = 0; end
    for (int i = 0; i < n; i++) dd[i] = o[i] - ((e[i] + ((i + 1 < n) ? e[i+1] : e[i])) >>> 1);
    for (int i = 0; i < n; i++) begin
      s[i] = fit(e[i] + ((((i == 0) ? dd[0] : dd[i-1]) + dd[i] + 2) >>> 2));
      d[i] = fit(dd[i]);
    end
  endfunction

  int le[4], lo[4], xs[4], xd[4];
  int base, d0;

  task automatic start_line();
    base = got_s.size();
    d0   = done_cnt;
    for (int i = 0; i < NP; i++) begin
      fe[e_wr % 256] = le[i]; e_wr++;
      fo[o_wr % 256] = lo[i]; o_wr++;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic finish_line(input string tag, input bit rnd);
    int k = 0;
    while (done_cnt == d0 && k < 500) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      odd_hold  = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      k++;
    end
    out_ready = 1'b1;
    odd_hold  = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_n_out"}, got_s.size() - base, NP);
    for (int i = 0; i < NP; i++) begin
      check({tag, "_s"}, (base + i < got_s.size()) ? 32'(got_s[base+i]) : 'x, xs[i]);
      check({tag, "_d"}, (base + i < got_d.size()) ? 32'(got_d[base+i]) : 'x, xd[i]);
    end
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_viol"}, viol, 0);
  endtask

  task automatic set_ramp();
    le = '{10, 20, 30, 40};
    lo = '{15, 25, 35, 45};
    xs = '{10, 20, 30, 41};
    xd = '{0, 0, 0, 5};
  endtask

  initial begin
    int k;
    logic [DW-1:0] rv;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(even_rd_en | odd_rd_en), 0);
    check("rst_approx", 32'(approx_out), 0);
    check("rst_detail", 32'(detail_out), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-pair floor and saturation/wrap lines
    start1 = 1'b1; start2 = 1'b1;
    @(negedge clk) begin start1 = 1'b0; start2 = 1'b0; end
    repeat (20) @(negedge clk);
    check("n1_count", g1s.size(), 1);
    check("n1_s", 32'(g1s[0]), -1);
    check("n1_d", 32'(g1d[0]), -3);
    check("n1_busy", 32'(b1), 0);
    check("n2_count", g2s.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check("n2_s", 32'(g2s[i]), 0);
`ifdef DWT_SAT_EN
      check("n2_d", 32'(g2d[i]), 32767);
`else
      check("n2_d", 32'(g2d[i]), -1);
`endif
    end

    set_ramp();
    start_line();
    finish_line("ramp", 1'b0);

    // Backpressure: hold out_ready low from the first valid pair
    set_ramp();
    out_ready = 1'b0;
    start_line();
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    check("bp_valid_seen", 32'(out_valid), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(out_valid), 1);
      check("bp_s_held", 32'($signed(approx_out)), 10);
      check("bp_d_held", 32'($signed(detail_out)), 0);
      check("bp_no_rd", 32'(even_rd_en | odd_rd_en), 0);
    end
    finish_line("bp", 1'b0);

    // Odd FIFO reports empty for 5 cycles mid-line
    set_ramp();
    start_line();
    k = 0;
    while (got_s.size() == base && k < 50) begin @(negedge clk); k++; end
    check("stall_first_out", got_s.size() - base, 1);
    odd_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check("stall_no_rd", 32'(even_rd_en | odd_rd_en), 0);
      @(negedge clk);
    end
    odd_hold = 1'b0;
    finish_line("stall", 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NP; i++) begin
        rv = DW'($urandom); le[i] = int'($signed(rv));
        rv = DW'($urandom); lo[i] = int'($signed(rv));
      end
      model(NP, le, lo, xs, xd);
      start_line();
      finish_line("rand", 1'b1);
    end

    // Reset after the second output of a line
    set_ramp();
    start_line();
    k = 0;
    while (got_s.size() < base + 2 && k < 80) begin @(negedge clk); k++; end
    check("mid_two_out", got_s.size() - base, 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    fifo_clr = 1'b1;
    @(negedge clk) fifo_clr = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    set_ramp();
    start_line();
    finish_line("after_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
